// File: rtl/aes_pkg.sv
// Shared AES datapath types and helpers used by the ShiftRows loader and the mix_column stage.
// The state is indexed [row][col]. Packed form puts byte (r,c) at bits [127-8*(4*c+r) -: 8].
package aes_pkg;

  typedef logic [7:0] byte_t;
  typedef byte_t state_t [3:0][3:0];

  localparam int unsigned AES_BLOCK_BYTES = 16;

  typedef enum logic [1:0] {BUF_EMPTY, BUF_FILLING, BUF_FULL} buf_st_e;

  // Destination column for a byte arriving at (r,c); the 2-bit subtraction wraps mod 4.
  function automatic logic [1:0] shift_col(input logic [1:0] r, input logic [1:0] c);
    return c - r;
  endfunction

  function automatic logic [127:0] pack_state(input state_t s);
    logic [127:0] p;
    p = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        p[127-8*(4*c+r) -: 8] = s[r][c];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_state_buf.sv
// One 16-byte state buffer with its EMPTY/FILLING/FULL tracker and a byte write port.
// The packed contents are presented continuously; the owner decides when they are valid.
module aes_state_buf
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en_i,
  input  logic [1:0]   wr_row_i,
  input  logic [1:0]   wr_col_i,
  input  logic [7:0]   wr_data_i,
  input  logic         wr_last_i,
  input  logic         wr_abort_i,
  input  logic         rd_done_i,
  output logic         full_o,
  output logic [127:0] state_o
);

  buf_st_e st_q, st_d;
  state_t  mem_q, mem_d;

  always_comb begin
    st_d  = st_q;
    mem_d = mem_q;
    if (wr_en_i) begin
      // A framing abort consumes the byte but discards the partial block.
      if (wr_abort_i) begin
        st_d = BUF_EMPTY;
      end else begin
        mem_d[wr_row_i][wr_col_i] = wr_data_i;
        st_d = wr_last_i ? BUF_FULL : BUF_FILLING;
      end
    end
    if (rd_done_i) begin
      st_d = BUF_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= BUF_EMPTY;
      mem_q <= '{default: '0};
    end else begin
      st_q  <= st_d;
      mem_q <= mem_d;
    end
  end

  assign full_o  = (st_q == BUF_FULL);
  assign state_o = pack_state(mem_q);

endmodule

// File: rtl/aes_shift_rows_loader.sv
// Byte-serial to 128-bit state assembler applying ShiftRows on write, ping-pong buffered.
// Owns the byte counter, write/read pointers and the framing check; buffers hold the data.
module aes_shift_rows_loader
  import aes_pkg::*;
#(
  parameter bit          SHIFT_EN = 1'b1,
  parameter int unsigned NUM_BUF  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [7:0]   s_data,
  input  logic         s_last,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_state,
  output logic         err
);

  logic [3:0]   cnt_q, cnt_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic         err_q, err_d;

  logic [NUM_BUF-1:0] buf_full;
  logic [127:0]       buf_state [NUM_BUF];

  logic       in_xfer, out_xfer, last_byte, abort, complete;
  logic [1:0] wr_row, in_col, wr_col;

  assign in_xfer   = s_valid & s_ready;
  assign out_xfer  = m_valid & m_ready;
  assign last_byte = (cnt_q == 4'(AES_BLOCK_BYTES - 1));
  assign abort     = in_xfer & s_last & ~last_byte;
  assign complete  = in_xfer & last_byte;

  // Stream index k = 4*c + r, so the low bits are the row.
  assign wr_row = cnt_q[1:0];
  assign in_col = cnt_q[3:2];
  assign wr_col = SHIFT_EN ? shift_col(wr_row, in_col) : in_col;

  for (genvar g = 0; g < NUM_BUF; g++) begin : g_buf
    aes_state_buf u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en_i    (in_xfer & (wr_ptr_q == 1'(g))),
      .wr_row_i   (wr_row),
      .wr_col_i   (wr_col),
      .wr_data_i  (s_data),
      .wr_last_i  (last_byte),
      .wr_abort_i (abort),
      .rd_done_i  (out_xfer & (rd_ptr_q == 1'(g))),
      .full_o     (buf_full[g]),
      .state_o    (buf_state[g])
    );
  end

  assign s_ready = ~buf_full[wr_ptr_q];
  assign m_valid = buf_full[rd_ptr_q];
  assign m_state = buf_state[rd_ptr_q];
  assign err     = err_q;

  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    // Early s_last and missing s_last on byte 15 both flag a framing error.
    err_d    = in_xfer & (s_last ^ last_byte);
    if (in_xfer) begin
      cnt_d = abort ? 4'd0 : cnt_q + 4'd1;
    end
    if (complete && NUM_BUF == 2) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (out_xfer && NUM_BUF == 2) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= 4'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_aes_shift_rows_loader.sv
// Bench for aes_shift_rows_loader: a shifting and a plain-load instance share one stream and are
// checked against a block-level reference model plus fixed vectors and directed corner sequences.
module tb_aes_shift_rows_loader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_last = 1'b0;
  logic [7:0]   s_data = 8'h00;
  logic         m_ready = 1'b0;

  logic         s_ready, m_valid, err;
  logic [127:0] m_state;
  logic         s_ready_ns, m_valid_ns, err_ns;
  logic [127:0] m_state_ns;

  always #5 clk = ~clk;

  aes_shift_rows_loader #(.SHIFT_EN(1'b1), .NUM_BUF(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_state (m_state),
    .err     (err)
  );

  aes_shift_rows_loader #(.SHIFT_EN(1'b0), .NUM_BUF(2)) dut_ns (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready_ns),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid_ns),
    .m_ready (m_ready),
    .m_state (m_state_ns),
    .err     (err_ns)
  );

  typedef struct {
    logic [127:0] shf;
    logic [127:0] pln;
  } exp_t;

  typedef struct {
    logic [127:0] in_w;
    logic [127:0] shf;
    logic [127:0] pln;
  } vec_t;

  exp_t       q[$];
  logic [7:0] mb [16];
  int         mk = 0;
  logic       err_pred = 1'b0;
  int         n_pass = 0;
  int         n_total = 0;
  vec_t       vecs [2];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_bound(input string name);
    n_total++;
    $display("FAIL %s: got timeout expected event within bound", name);
  endtask

  // Reference: out[r][c] = in[r][(c+r) mod 4] for the shifted view, identity for the plain view.
  function automatic exp_t build_exp();
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        e.shf[127-8*(4*c+r) -: 8] = mb[4*((c + r) % 4) + r];
        e.pln[127-8*(4*c+r) -: 8] = mb[4*c + r];
      end
    end
    return e;
  endfunction

  task automatic monitor();
    logic sr_e, mv_e;
    exp_t blk;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        mk = 0;
        err_pred = 1'b0;
      end else begin
        sr_e = (q.size() < 2);
        mv_e = (q.size() != 0);
        chk1("s_ready", s_ready, sr_e);
        chk1("s_ready_ns", s_ready_ns, sr_e);
        chk1("m_valid", m_valid, mv_e);
        chk1("m_valid_ns", m_valid_ns, mv_e);
        chk1("err", err, err_pred);
        chk1("err_ns", err_ns, err_pred);
        if (mv_e) begin
          chk128("m_state", m_state, q[0].shf);
          chk128("m_state_ns", m_state_ns, q[0].pln);
        end
        err_pred = 1'b0;
        if (mv_e && m_ready) blk = q.pop_front();
        if (s_valid && sr_e) begin
          if (s_last && mk != 15) begin
            err_pred = 1'b1;
            mk = 0;
          end else begin
            mb[mk] = s_data;
            if (mk == 15) begin
              q.push_back(build_exp());
              err_pred = !s_last;
              mk = 0;
            end else begin
              mk++;
            end
          end
        end
      end
    end
  endtask

  // Called and returns at posedge+1.
  task automatic send_byte(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) fail_bound("send_byte");
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] w, input int nbytes, input logic last_on_final);
    for (int k = 0; k < nbytes; k++) begin
      send_byte(w[127-8*k -: 8], last_on_final && (k == nbytes - 1));
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) fail_bound("drain");
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [127:0] held;
    int           mode, nb;
    logic         lst;

    vecs[0].in_w = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
    vecs[0].shf  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    vecs[0].pln  = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
    vecs[1].in_w = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    vecs[1].shf  = 128'h00050a0f_04090e03_080d0207_0c01060b;
    vecs[1].pln  = 128'h00010203_04050607_08090a0b_0c0d0e0f;

    fork
      monitor();
      begin
        #500000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
      end
    join_none

    #1 rst_n = 1'b0;
    #11;
    chk1("rst_s_ready", s_ready, 1'b1);
    chk1("rst_m_valid", m_valid, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk128("rst_m_state", m_state, 128'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fixed vectors: contents and one-cycle latency after byte 15.
    m_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send_block(vecs[i].in_w, 16, 1'b1);
      @(negedge clk);
      chk1("vec_m_valid", m_valid, 1'b1);
      chk128("vec_m_state", m_state, vecs[i].shf);
      chk128("vec_m_state_ns", m_state_ns, vecs[i].pln);
      @(posedge clk);
      #1;
    end
    wait_drain();

    // Stalled downstream: three blocks, the third must wait for a free buffer.
    m_ready = 1'b0;
    fork
      begin
        for (int b = 0; b < 3; b++) send_block(rnd128(), 16, 1'b1);
      end
      begin
        repeat (60) @(negedge clk);
        chk1("stall_s_ready", s_ready, 1'b0);
        held = m_state;
        repeat (5) @(negedge clk);
        chk128("stall_hold", m_state, held);
        @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    wait_drain();

    // Continuous streaming with m_ready held high.
    m_ready = 1'b1;
    for (int b = 0; b < 4; b++) send_block(rnd128(), 16, 1'b1);
    wait_drain();

    // Framing: early s_last at k=7, then a good block, then missing s_last.
    send_block(rnd128(), 8, 1'b1);
    @(negedge clk);
    chk1("early_last_err", err, 1'b1);
    @(posedge clk);
    #1;
    send_block(vecs[0].in_w, 16, 1'b1);
    send_block(vecs[1].in_w, 16, 1'b0);
    @(negedge clk);
    chk1("missing_last_err", err, 1'b1);
    chk1("missing_last_valid", m_valid, 1'b1);
    @(posedge clk);
    #1;
    wait_drain();

    // Reset with a full block pending and a partial block at byte 9.
    m_ready = 1'b0;
    send_block(vecs[0].in_w, 16, 1'b1);
    send_block(rnd128(), 9, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk1("midrst_m_valid", m_valid, 1'b0);
    chk1("midrst_s_ready", s_ready, 1'b1);
    chk1("midrst_err", err, 1'b0);
    chk128("midrst_m_state", m_state, 128'h0);
    chk128("midrst_m_state_ns", m_state_ns, 128'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_ready = 1'b1;
    send_block(vecs[1].in_w, 16, 1'b1);
    wait_drain();

    // Random traffic with gaps, random back-pressure and occasional framing errors.
    for (int b = 0; b < 20; b++) begin
      mode = int'($urandom_range(0, 7));
      nb   = (mode == 0) ? int'($urandom_range(1, 15)) : 16;
      lst  = (mode != 1);
      for (int k = 0; k < nb; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 2)) @(posedge clk);
          #1;
        end
        m_ready = 1'($urandom_range(0, 1));
        send_byte(8'($urandom_range(0, 255)), lst && (k == nb - 1));
      end
    end
    m_ready = 1'b1;
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
